uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_transmitter between NUM_REQ byte-stream requesters. Round-robin grant, packet-atomic:
//  a grant is held until the requester's last byte is accepted. Owns the transmitter configuration
//  (baudrate_select, buffer_full_threshold); new settings are applied only between packets.
//  Sits directly upstream of uart_transmitter and drives all of its inputs except clock/reset.
// PARAMETERS
//  NUM_REQ        4      number of requesters (2..8)
//  BAUD_DEFAULT   2'd0   tx_baudrate_select value after reset
//  THRESH_DEFAULT 6'd32  tx_buffer_full_threshold value after reset
//  TIMEOUT        255    idle cycles mid-packet before forced release (only with UART_TX_ARB_TIMEOUT_EN)
// PORTS
//  clock                    in   1          system clock, all logic on posedge
//  reset                    in   1          one clock; reset is asynchronous and active-high
//  req_valid                in   NUM_REQ    byte offered by requester i
//  req_data                 in   NUM_REQ*8  byte of requester i at bits [8i+7:8i]
//  req_last                 in   NUM_REQ    offered byte is last of packet
//  req_ready                out  NUM_REQ    byte of requester i accepted this cycle when valid&ready
//  cfg_write                in   1          request new transmitter configuration
//  cfg_baudrate_select      in   2          new baudrate select
//  cfg_threshold            in   6          new buffer-full threshold
//  cfg_pending              out  1          configuration captured, not yet applied
//  tx_write_enable          out  1          to transmitter write_enable
//  tx_data                  out  8          to transmitter data
//  tx_buffer_full_threshold out  6          to transmitter buffer_full_threshold
//  tx_baudrate_select       out  2          to transmitter baudrate_select
//  tx_buffer_full           in   1          from transmitter buffer_full
//  grant                    out  NUM_REQ    one-hot current owner, 0 when idle
//  busy                     out  1          packet in progress (state SEND)
//  timeout_event            out  1          one-cycle pulse on forced release; tied 0 without macro
// BEHAVIOUR
//  Reset: state IDLE, grant 0, busy 0, cfg_pending 0, timeout_event 0, rr pointer 0,
//   tx_baudrate_select=BAUD_DEFAULT, tx_buffer_full_threshold=THRESH_DEFAULT; combinational outputs follow (all 0).
//  FSM IDLE/CFG/SEND, registered:
//   IDLE: cfg_pending -> CFG (priority over requests); else any req_valid -> SEND, grant=rr pick.
//   CFG: one cycle; load tx_* config regs from pending copy, clear cfg_pending -> IDLE.
//   SEND: transfer when req_valid[g] & !tx_buffer_full; transfer with req_last -> IDLE,
//    rr pointer = g+1 mod NUM_REQ (wraps NUM_REQ-1 -> 0).
//  Grant latency: request seen in IDLE -> grant asserted next cycle; first byte may transfer that cycle.
//  Datapath combinational in SEND: req_ready[g] = !tx_buffer_full; tx_write_enable = req_valid[g] & !tx_buffer_full;
//   tx_data = req_data[g] (0 when idle). Non-granted req_ready always 0.
//  tx_buffer_full high: no transfer, requester holds byte; packet stays granted.
//  cfg_write: capture values, set cfg_pending any state; cfg_write while pending overwrites (last wins).
//   Never applied mid-packet; tx_* config changes only in CFG.
//  Round robin: search starts at rr pointer; lone requester re-granted immediately after its packet.
//  req_valid dropping mid-packet: grant held (bubble), no transfer.
//  Async reset mid-packet: immediate return to reset values; partial packet abandoned.
// CONFIGURATION
//  UART_TX_ARB_TIMEOUT_EN defined: counter in SEND counts cycles with req_valid[g]=0 (clears on valid);
//   reaching TIMEOUT -> IDLE, timeout_event pulse 1 cycle, rr pointer advances past g. Full buffer never counts.
//  Undefined: no counter, grant held indefinitely, timeout_event constant 0.
// STRUCTURE
//  Package uart_tx_pkg: state enum (IDLE, CFG, SEND), BAUD/THRESH width localparams, cfg struct {baud, thresh}.
//  Sub-module uart_rr_picker: combinational one-hot round-robin select from req vector and pointer.
// TESTING
//  Reset: all outputs as listed; tx_baudrate_select=0, tx_buffer_full_threshold=32, grant=0.
//  Req0 3-byte packet 0x11,0x22,0x33(last), buffer never full -> grant=0001 one cycle later, 3 consecutive
//   tx_write_enable pulses with matching tx_data, IDLE after last.
//  Req0,Req2 continuous 2-byte packets -> grants alternate 0001,0100,0001; no interleaved bytes within a packet.
//  tx_buffer_full high 4 cycles mid-packet -> tx_write_enable 0, req_ready 0, byte held; resumes unchanged.
//  cfg_write baud=3 thresh=10 mid-packet -> cfg_pending=1 until packet end, CFG cycle, then outputs 3/10.
//  Timeout (macro on, TIMEOUT=8): req1 sends 1 non-last byte then idles -> release after 8 cycles,
//   timeout_event pulse, waiting req2 granted next.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and widths for the uart_tx_arbiter slice.
// Optional build macro: UART_TX_ARB_TIMEOUT_EN (mid-packet idle timeout).
package uart_tx_pkg;

    localparam int BAUD_W   = 2;
    localparam int THRESH_W = 6;

    // Arbiter FSM: IDLE picks the next owner, CFG applies pending settings,
    // SEND streams one packet from the granted requester.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CFG  = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    // Transmitter configuration as one unit so capture and apply stay atomic.
    typedef struct packed {
        logic [BAUD_W-1:0]   baud;
        logic [THRESH_W-1:0] thresh;
    } cfg_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: scans the request vector starting at
// the pointer and returns the first active requester, one-hot and as index.
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    // First requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one uart_transmitter between
// NUM_REQ byte streams; also owns the transmitter configuration and only
// changes it between packets.
// Optional build macro: UART_TX_ARB_TIMEOUT_EN forces release of a grant
// after TIMEOUT idle cycles mid-packet and pulses timeout_event.
// Handshake: a byte moves on a clock edge where req_valid[i] & req_ready[i];
// req_ready is only ever high for the granted requester and only while the
// transmitter buffer is not full. tx_write_enable mirrors that transfer.
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int                  NUM_REQ        = 4,
    parameter logic [BAUD_W-1:0]   BAUD_DEFAULT   = 2'd0,
    parameter logic [THRESH_W-1:0] THRESH_DEFAULT = 6'd32,
    parameter int                  TIMEOUT        = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   cfg_write,
    input  logic [BAUD_W-1:0]      cfg_baudrate_select,
    input  logic [THRESH_W-1:0]    cfg_threshold,
    output logic                   cfg_pending,
    output logic                   tx_write_enable,
    output logic [7:0]             tx_data,
    output logic [THRESH_W-1:0]    tx_buffer_full_threshold,
    output logic [BAUD_W-1:0]      tx_baudrate_select,
    input  logic                   tx_buffer_full,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   timeout_event,
    output logic [1:0]             dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    cfg_t               pend_q, pend_d;
    logic               cfg_pending_q, cfg_pending_d;
    cfg_t               txcfg_q, txcfg_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               xfer;
    logic               to_expire;
    logic [IDX_W-1:0]   rr_after_g;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i     (req_valid),
        .ptr_i     (rr_q),
        .gnt_o     (pick_gnt),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    // Datapath is combinational from the held grant; nothing moves outside SEND.
    assign busy            = (state_q == ST_SEND);
    assign xfer            = busy && !tx_buffer_full && req_valid[gidx_q];
    assign tx_write_enable = xfer;
    assign req_ready       = (busy && !tx_buffer_full) ? grant_q : '0;
    assign tx_data         = busy ? req_data[{gidx_q, 3'b000} +: 8] : 8'h00;
    assign grant           = grant_q;
    assign cfg_pending     = cfg_pending_q;
    assign tx_baudrate_select       = txcfg_q.baud;
    assign tx_buffer_full_threshold = txcfg_q.thresh;
    assign dbg_state       = state_q;
    assign rr_after_g      = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

    // Next-state: FSM, grant, round-robin pointer and configuration capture/apply.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        rr_d          = rr_q;
        pend_d        = pend_q;
        cfg_pending_d = cfg_pending_q;
        txcfg_d       = txcfg_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_pending_q) begin
                    state_d = ST_CFG;
                end else if (pick_any) begin
                    state_d = ST_SEND;
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                end
            end
            ST_CFG: begin
                txcfg_d       = pend_q;
                cfg_pending_d = 1'b0;
                state_d       = ST_IDLE;
            end
            ST_SEND: begin
                if ((xfer && req_last[gidx_q]) || to_expire) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    rr_d    = rr_after_g;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        // A write in any state (including CFG) wins over the clear: last value wins.
        if (cfg_write) begin
            pend_d        = '{baud: cfg_baudrate_select, thresh: cfg_threshold};
            cfg_pending_d = 1'b1;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            rr_q          <= '0;
            pend_q        <= '{baud: BAUD_DEFAULT, thresh: THRESH_DEFAULT};
            cfg_pending_q <= 1'b0;
            txcfg_q       <= '{baud: BAUD_DEFAULT, thresh: THRESH_DEFAULT};
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            gidx_q        <= gidx_d;
            rr_q          <= rr_d;
            pend_q        <= pend_d;
            cfg_pending_q <= cfg_pending_d;
            txcfg_q       <= txcfg_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_event_q;

    // Only cycles with the owner's valid low count; a full buffer never does.
    assign to_expire = busy && !req_valid[gidx_q] && (to_cnt_q == TO_W'(TIMEOUT - 1));

    // Idle-cycle counter next value: clears on valid, outside SEND, or on expiry.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (!busy || req_valid[gidx_q] || to_expire) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Timeout counter and one-cycle release pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt_q   <= '0;
            to_event_q <= 1'b0;
        end else begin
            to_cnt_q   <= to_cnt_d;
            to_event_q <= to_expire;
        end
    end

    assign timeout_event = to_event_q;
`else
    assign to_expire     = 1'b0;
    assign timeout_event = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Expected transfers are derived
// from the packet queues and the round-robin rule, pushed into exp_q, and
// popped by an independent monitor on every tx_write_enable.
// Build with UART_TX_ARB_TIMEOUT_EN defined to exercise the timeout path.
module tb_uart_tx_arbiter;
  import uart_tx_pkg::*;

  localparam int NUM_REQ = 4;

  logic                 clock;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 cfg_write;
  logic [1:0]           cfg_baudrate_select;
  logic [5:0]           cfg_threshold;
  logic                 cfg_pending;
  logic                 tx_write_enable;
  logic [7:0]           tx_data;
  logic [5:0]           tx_buffer_full_threshold;
  logic [1:0]           tx_baudrate_select;
  logic                 tx_buffer_full;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 timeout_event;
  logic [1:0]           dbg_state;

  int checks = 0;
  int errors = 0;
  int tb_rr  = 0;
  int run [NUM_REQ];

  // Expected transfers: {requester id[2:0], byte[7:0]}.
  logic [10:0] exp_q [$];
  // Bytes each requester still has to offer: {last, byte}.
  logic [8:0]  src_q [NUM_REQ][$];

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .BAUD_DEFAULT(2'd0), .THRESH_DEFAULT(6'd32), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .cfg_write(cfg_write), .cfg_baudrate_select(cfg_baudrate_select), .cfg_threshold(cfg_threshold),
    .cfg_pending(cfg_pending),
    .tx_write_enable(tx_write_enable), .tx_data(tx_data),
    .tx_buffer_full_threshold(tx_buffer_full_threshold), .tx_baudrate_select(tx_baudrate_select),
    .tx_buffer_full(tx_buffer_full),
    .grant(grant), .busy(busy), .timeout_event(timeout_event), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cfg_pending"}, cfg_pending, 0);
    check({tag, "_timeout_event"}, timeout_event, 0);
    check({tag, "_tx_we"}, tx_write_enable, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_baud"}, tx_baudrate_select, 0);
    check({tag, "_thresh"}, tx_buffer_full_threshold, 32);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  task automatic add_pkt(input int id, input int len);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      src_q[id].push_back({(k == len - 1), b});
    end
  endtask

  function automatic int pending_bytes();
    int n = 0;
    for (int i = 0; i < NUM_REQ; i++) n += src_q[i].size();
    return n;
  endfunction

  // Reference: every loaded requester keeps offering, so packets leave in
  // round-robin order, one whole packet at a time, pointer = owner + 1.
  function automatic void model_order();
    int rd [NUM_REQ];
    int left [NUM_REQ];
    int total = 0;
    int j;
    bit found;
    logic [8:0] e;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd[i] = 0;
      left[i] = 0;
      foreach (src_q[i][k]) begin
        e = src_q[i][k];
        if (e[8]) left[i]++;
      end
      total += left[i];
    end
    while (total > 0) begin
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (tb_rr + k) % NUM_REQ;
        if (!found && left[j] > 0) begin
          found = 1'b1;
          do begin
            e = src_q[j][rd[j]];
            exp_q.push_back({3'(j), e[7:0]});
            rd[j]++;
          end while (!e[8]);
          left[j]--;
          total--;
          tb_rr = (j + 1) % NUM_REQ;
        end
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic present(input bit rnd);
    logic [8:0] hd;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        hd = src_q[i][0];
        req_data[i*8 +: 8] = hd[7:0];
        req_last[i] = hd[8];
        if (rnd && grant[i] && run[i] < 3 && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b0;
          run[i]++;
        end else begin
          req_valid[i] = 1'b1;
          run[i] = 0;
        end
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic drive_pkts(input int budget, input bit rnd, input bit full_hold);
    int cyc = 0;
    int hold = 0;
    bit held_done = 1'b0;
    logic [NUM_REQ-1:0] acc;
    for (int i = 0; i < NUM_REQ; i++) run[i] = 0;
    model_order();
    tx_buffer_full = 1'b0;
    present(rnd);
    while (pending_bytes() > 0 && cyc < budget) begin
      @(negedge clock);
      acc = req_valid & req_ready;
      if (full_hold && tx_buffer_full) begin
        check("full_no_write", tx_write_enable, 0);
        check("full_no_ready", req_ready, 0);
        check("full_grant_held", busy, 1);
      end
      @(posedge clock);
      #1;
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) if (acc[i]) void'(src_q[i].pop_front());
      if (full_hold && !held_done && acc != 0) begin
        hold = 4;
        held_done = 1'b1;
      end
      if (hold > 0) begin
        tx_buffer_full = 1'b1;
        hold--;
      end else begin
        tx_buffer_full = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      present(rnd);
    end
    check("drive_budget", (cyc < budget), 1);
    req_valid = '0;
    req_last = '0;
    tx_buffer_full = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [10:0] mon_e;
  int          mon_gi;
  always @(negedge clock) begin
    if (!reset && tx_write_enable) begin
      mon_gi = onehot_idx(grant);
      check("xfer_ready_is_grant", req_ready, grant);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got req %0d data 0x%0h expected no transfer at %0t",
                 mon_gi, tx_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("xfer_owner", mon_gi, 32'(mon_e[10:8]));
        check("xfer_data", tx_data, 32'(mon_e[7:0]));
      end
    end
    if (!reset && !busy) check("idle_no_write", tx_write_enable, 0);
  end

  // ---------------- stimulus ----------------
  int n_idle;
  bit done;
  int w;

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    cfg_write = 1'b0;
    cfg_baudrate_select = '0;
    cfg_threshold = '0;
    tx_buffer_full = 1'b0;
    #3;
    check_reset_vals("reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_vals("after_reset");

    // Req0 3-byte packet: grant one cycle after the request, three back-to-back writes.
    @(posedge clock);
    #1;
    exp_q.push_back({3'd0, 8'h11});
    exp_q.push_back({3'd0, 8'h22});
    exp_q.push_back({3'd0, 8'h33});
    tb_rr = 1;
    req_valid[0] = 1'b1; req_data[7:0] = 8'h11; req_last[0] = 1'b0;
    @(negedge clock);
    check("grant_before_latency", grant, 0);
    @(negedge clock);
    check("grant_after_latency", grant, 4'b0001);
    check("first_byte_we", tx_write_enable, 1);
    @(posedge clock); #1 req_data[7:0] = 8'h22;
    @(negedge clock);
    check("second_byte_we", tx_write_enable, 1);
    @(posedge clock); #1 req_data[7:0] = 8'h33; req_last[0] = 1'b1;
    @(negedge clock);
    check("third_byte_we", tx_write_enable, 1);
    @(posedge clock); #1 req_valid[0] = 1'b0; req_last[0] = 1'b0;
    @(negedge clock);
    check("idle_after_last_busy", busy, 0);
    check("idle_after_last_grant", grant, 0);

    // Req0 and Req2 continuous 2-byte packets: alternate whole packets.
    add_pkt(0, 2); add_pkt(0, 2); add_pkt(2, 2); add_pkt(2, 2);
    drive_pkts(200, 1'b0, 1'b0);

    // Buffer full for 4 cycles mid-packet: byte held, stream resumes unchanged.
    add_pkt(1, 3);
    drive_pkts(200, 1'b0, 1'b1);

    // Config write mid-packet (twice, last wins): applied only after the packet.
    add_pkt(3, 8);
    fork
      drive_pkts(200, 1'b0, 1'b0);
      begin
        w = 0;
        while (!busy && w < 50) begin @(negedge clock); w++; end
        @(posedge clock); #1 cfg_write = 1'b1; cfg_baudrate_select = 2'd1; cfg_threshold = 6'd5;
        @(posedge clock); #1 cfg_baudrate_select = 2'd3; cfg_threshold = 6'd10;
        @(posedge clock); #1 cfg_write = 1'b0;
        @(negedge clock);
        check("cfg_pending_mid_pkt", cfg_pending, 1);
        check("cfg_mid_pkt_busy", busy, 1);
        check("cfg_mid_pkt_baud_old", tx_baudrate_select, 0);
        check("cfg_mid_pkt_thresh_old", tx_buffer_full_threshold, 32);
      end
    join
    @(negedge clock);
    check("cfg_pending_at_pkt_end", cfg_pending, 1);
    check("cfg_baud_before_apply", tx_baudrate_select, 0);
    @(negedge clock);
    check("cfg_state_cfg", dbg_state, ST_CFG);
    @(negedge clock);
    check("cfg_pending_cleared", cfg_pending, 0);
    check("cfg_baud_applied", tx_baudrate_select, 3);
    check("cfg_thresh_applied", tx_buffer_full_threshold, 10);

    // Randomized rounds with bubbles on the owner and random back-pressure.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(0, 1) == 1)
          for (int p = 0; p < $urandom_range(1, 3); p++) add_pkt(i, $urandom_range(1, 4));
      if (pending_bytes() == 0) add_pkt($urandom_range(0, NUM_REQ - 1), $urandom_range(1, 4));
      drive_pkts(3000, 1'b1, 1'b0);
      check("random_round_drained", exp_q.size(), 0);
      check("random_no_timeout", timeout_event, 0);
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Req1 stalls after one non-last byte: forced release after 8 idle cycles.
    @(posedge clock);
    #1;
    req_valid[1] = 1'b1; req_data[15:8] = 8'hA5; req_last[1] = 1'b0;
    exp_q.push_back({3'd1, 8'hA5});
    w = 0;
    do begin @(negedge clock); w++; end while (grant != 4'b0010 && w < 20);
    check("to_req1_granted", grant, 4'b0010);
    @(posedge clock);
    #1;
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b1; req_data[23:16] = 8'h5A; req_last[2] = 1'b1;
    exp_q.push_back({3'd2, 8'h5A});
    n_idle = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      if (busy && grant == 4'b0010) n_idle++;
      else done = 1'b1;
    end
    check("to_idle_cycles", n_idle, 8);
    check("to_event_pulse", timeout_event, 1);
    check("to_released_grant", grant, 0);
    @(negedge clock);
    check("to_event_one_cycle", timeout_event, 0);
    check("to_req2_granted_next", grant, 4'b0100);
    @(posedge clock); #1 req_valid[2] = 1'b0; req_last[2] = 1'b0;
    @(negedge clock);
    check("to_req2_done", busy, 0);
`endif

    // Mid-packet bubble then asynchronous reset abandoning the packet.
    @(posedge clock);
    #1;
    req_valid[1] = 1'b1; req_data[15:8] = 8'hC3; req_last[1] = 1'b0;
    exp_q.push_back({3'd1, 8'hC3});
    w = 0;
    do begin @(negedge clock); w++; end while (grant != 4'b0010 && w < 20);
    @(posedge clock); #1 req_valid[1] = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    repeat (3) @(negedge clock);
    check("bubble_grant_held", grant, 4'b0010);
`else
    n_idle = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (busy && grant == 4'b0010 && !timeout_event) n_idle++;
    end
    check("no_timeout_grant_held", n_idle, 20);
`endif
    #2 reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    @(posedge clock);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("after_async_reset_idle", busy, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
